gcd_job_issuer: RTL

- Initiator side of the GCD core handshake (go / x / y in, done / gcd out).
- Accepts operand pairs from an upstream valid/ready source and drives go, x and y to the GCD core.
- Waits for done, captures the result, and presents it downstream on a valid/ready result port.
- Shields the core from zero operands, which would hang the subtractive loop, and guards every job with a timeout.

---
 rtl/gcd_job_issuer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/gcd_job_issuer.sv
// Issues operand pairs to a subtractive GCD core and returns the result on a valid/ready port.
// Latency: zero-operand job -> res_valid 1 cycle after accept; core job -> done delay + 2 cycles.
// Backpressure: job_ready only in IDLE (one job in flight); result held stable until res_ready.
// Optional build macro GCD_ISSUER_STATS_EN adds saturating job/error counters (stat_jobs, stat_errs).
module gcd_job_issuer #(
    parameter int W       = 4,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [W-1:0] job_a,
    input  logic [W-1:0] job_b,
    output logic         go_o,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o,
    input  logic         done_i,
    input  logic [W-1:0] gcd_i,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_gcd,
    output logic         res_err,
    output logic         res_timeout
`ifdef GCD_ISSUER_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_jobs,
    output logic [CNT_W-1:0] stat_errs
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    // Last count value of a WAIT phase; the abort fires when the counter would reach TIMEOUT.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_cnt_nxt;
    logic [W-1:0]     x_nxt;
    logic [W-1:0]     y_nxt;
    logic [W-1:0]     gcd_nxt;
    logic             err_nxt;
    logic             tmo_nxt;

    // Next-state and next result values; everything is registered below so outputs are glitch-free.
    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        x_nxt       = x_o;
        y_nxt       = y_o;
        gcd_nxt     = res_gcd;
        err_nxt     = res_err;
        tmo_nxt     = res_timeout;
        case (state)
            S_IDLE: begin
                if (job_valid && job_ready) begin
                    x_nxt = job_a;
                    y_nxt = job_b;
                    tmo_nxt = 1'b0;
                    if (job_a == '0 && job_b == '0) begin
                        // Both zero has no defined GCD and would spin the core forever.
                        state_nxt = S_RESP;
                        gcd_nxt   = '0;
                        err_nxt   = 1'b1;
                    end else if (job_a == '0) begin
                        // gcd(0, b) = b; answer locally, the core would never terminate.
                        state_nxt = S_RESP;
                        gcd_nxt   = job_b;
                        err_nxt   = 1'b0;
                    end else if (job_b == '0) begin
                        state_nxt = S_RESP;
                        gcd_nxt   = job_a;
                        err_nxt   = 1'b0;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                tmo_cnt_nxt = '0;
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                tmo_cnt_nxt = tmo_cnt + 1'b1;
                if (done_i) begin
                    // A done on the final timeout cycle still wins.
                    state_nxt = S_RESP;
                    gcd_nxt   = gcd_i;
                    err_nxt   = 1'b0;
                    tmo_nxt   = 1'b0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_RESP;
                    gcd_nxt   = '0;
                    err_nxt   = 1'b1;
                    tmo_nxt   = 1'b1;
                end
            end
            S_RESP: begin
                if (res_valid && res_ready) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Core must drop done (return to idle) before it can take another go.
                if (!done_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            job_ready   <= 1'b0;
            go_o        <= 1'b0;
            x_o         <= '0;
            y_o         <= '0;
            res_valid   <= 1'b0;
            res_gcd     <= '0;
            res_err     <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            job_ready   <= (state_nxt == S_IDLE);
            go_o        <= (state_nxt == S_ISSUE) || (state_nxt == S_WAIT);
            x_o         <= x_nxt;
            y_o         <= y_nxt;
            res_valid   <= (state_nxt == S_RESP);
            res_gcd     <= gcd_nxt;
            res_err     <= err_nxt;
            res_timeout <= tmo_nxt;
        end
    end

`ifdef GCD_ISSUER_STATS_EN
    logic res_accept;
    assign res_accept = res_valid && res_ready;

    // Saturating counters of accepted results and of accepted error results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_jobs <= '0;
            stat_errs <= '0;
        end else if (res_accept) begin
            if (stat_jobs != '1) begin
                stat_jobs <= stat_jobs + 1'b1;
            end
            if (res_err && (stat_errs != '1)) begin
                stat_errs <= stat_errs + 1'b1;
            end
        end
    end
`endif

endmodule
